rng_pool: RTL and testbench

Parametrised random-bit pool between the SHAKE256 extractor and the Gaussian sampler datapath. It absorbs fixed-width words through the existing `rng_valid`/`rng`/`rng_extract` handshake and serves variable-length draws of 1..OUT_W bits per cycle. This lets several sampler generations (base sampler, BerExp, sign bit) share one extractor without wasting bits. The pool replaces the fixed 128-bit capture inside the previous sampler and adds variable-length draws, back-pressure and flush.

---
 rtl/rng_pool.sv | 126 ++++++++++++
 tb/tb_rng_pool.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_pool.sv
// Random-bit pool between the SHAKE256 extractor and the sampler datapath.
// Absorbs IN_W-bit words and serves draws of 1..OUT_W bits per cycle.
module rng_pool #(
   parameter int IN_W      = 128,
   parameter int OUT_W     = 72,
   parameter int BUF_W     = 256,
   parameter bit MSB_FIRST = 1'b0,
   parameter int LEN_W     = $clog2(OUT_W + 1),
   localparam int FILL_W   = $clog2(BUF_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rng_valid,
   input  logic [IN_W-1:0]   rng,
   output logic              rng_extract,
   input  logic              flush,
   input  logic              req,
   input  logic [LEN_W-1:0]  req_len,
   output logic              req_ready,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic [FILL_W-1:0] fill
);

   logic [BUF_W-1:0]  pool_q, pool_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              extract_q, extract_d;
   logic              out_valid_q, out_valid_d;
   logic [OUT_W-1:0]  out_data_q, out_data_d;

   logic [LEN_W-1:0]  eff_len_s;
   logic              draw_s;
   logic              absorb_s;
   logic              room_ok_s;
   logic [FILL_W-1:0] drawn_s;
   logic [FILL_W-1:0] rem_s;
   logic [BUF_W-1:0]  shifted_s;
   logic [OUT_W-1:0]  draw_raw_s;
   logic [OUT_W-1:0]  draw_bits_s;

   function automatic logic [OUT_W-1:0] bit_rev(input logic [OUT_W-1:0] v);
      logic [OUT_W-1:0] r;
      for (int i = 0; i < OUT_W; i++) begin
         r[i] = v[OUT_W-1-i];
      end
      return r;
   endfunction

   // Length clamp, readiness and draw/absorb decisions.
   always_comb begin
      if ((req_len == {LEN_W{1'b0}}) || (req_len > LEN_W'(OUT_W))) begin
         eff_len_s = LEN_W'(OUT_W);
      end else begin
         eff_len_s = req_len;
      end
      req_ready = !flush && (fill_q >= FILL_W'(eff_len_s));
      draw_s    = req && req_ready;
      if (draw_s) begin
         drawn_s = FILL_W'(eff_len_s);
      end else begin
         drawn_s = {FILL_W{1'b0}};
      end
      rem_s     = fill_q - drawn_s;
      room_ok_s = ({1'b0, rem_s} + (FILL_W + 1)'(IN_W)) <= (FILL_W + 1)'(BUF_W);
      absorb_s  = rng_valid && !extract_q && !flush && room_ok_s;
   end

   // Next pool contents and fill: shift out drawn bits, append the word above the survivors.
   always_comb begin
      shifted_s = pool_q >> drawn_s;
      pool_d    = shifted_s;
      fill_d    = rem_s;
      if (flush) begin
         pool_d = pool_q;
         fill_d = {FILL_W{1'b0}};
      end else if (absorb_s) begin
         // Stale bits above the survivors must be cleared before the OR.
         pool_d = (shifted_s & ~({BUF_W{1'b1}} << rem_s))
                | ({{(BUF_W - IN_W){1'b0}}, rng} << rem_s);
         fill_d = rem_s + FILL_W'(IN_W);
      end else begin
         pool_d = shifted_s;
         fill_d = rem_s;
      end
   end

   // Draw result: low len bits, optionally reversed within the draw.
   always_comb begin
      draw_raw_s = pool_q[OUT_W-1:0] & ~({OUT_W{1'b1}} << eff_len_s);
      if (MSB_FIRST) begin
         draw_bits_s = bit_rev(draw_raw_s) >> (LEN_W'(OUT_W) - eff_len_s);
      end else begin
         draw_bits_s = draw_raw_s;
      end
      if (draw_s) begin
         out_data_d = draw_bits_s;
      end else begin
         out_data_d = {OUT_W{1'b0}};
      end
      out_valid_d = draw_s;
      extract_d   = absorb_s;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pool_q      <= {BUF_W{1'b0}};
         fill_q      <= {FILL_W{1'b0}};
         extract_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {OUT_W{1'b0}};
      end else begin
         pool_q      <= pool_d;
         fill_q      <= fill_d;
         extract_q   <= extract_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign rng_extract = extract_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign fill        = fill_q;

endmodule

// File: tb/tb_rng_pool.sv
// Bench for rng_pool: LSB-order and MSB-order instances share stimulus and are
// checked every cycle against a bit-queue model, plus hand-computed literals.
module tb_rng_pool;

   localparam int IN_W   = 128;
   localparam int OUT_W  = 72;
   localparam int BUF_W  = 256;
   localparam int LEN_W  = 7;
   localparam int FILL_W = 9;

   localparam logic [IN_W-1:0] W1 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
   localparam logic [IN_W-1:0] W3 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [IN_W-1:0] W4 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

   logic              clk = 1'b0;
   logic              rst_n, rng_valid, flush, req;
   logic [IN_W-1:0]   rng;
   logic [LEN_W-1:0]  req_len;

   logic              ext_l, rdy_l, ov_l, ext_m, rdy_m, ov_m;
   logic [OUT_W-1:0]  od_l, od_m;
   logic [FILL_W-1:0] fill_l, fill_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rng_pool #(.IN_W(IN_W), .OUT_W(OUT_W), .BUF_W(BUF_W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .rng_valid(rng_valid), .rng(rng), .rng_extract(ext_l),
      .flush(flush), .req(req), .req_len(req_len), .req_ready(rdy_l),
      .out_valid(ov_l), .out_data(od_l), .fill(fill_l));

   rng_pool #(.IN_W(IN_W), .OUT_W(OUT_W), .BUF_W(BUF_W), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .rng_valid(rng_valid), .rng(rng), .rng_extract(ext_m),
      .flush(flush), .req(req), .req_len(req_len), .req_ready(rdy_m),
      .out_valid(ov_m), .out_data(od_m), .fill(fill_m));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff_len(input logic [LEN_W-1:0] l);
      if (l == 7'd0 || int'(l) > OUT_W) return OUT_W;
      return int'(l);
   endfunction

   // Model: the pool is a queue of bits, front = next bit out.
   bit               mq[$];
   logic             m_ext = 1'b0;
   logic             m_valid = 1'b0;
   logic [OUT_W-1:0] m_data_l = '0;
   logic [OUT_W-1:0] m_data_m = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_ext    <= 1'b0;
         m_valid  <= 1'b0;
         m_data_l <= '0;
         m_data_m <= '0;
      end else begin
         int len;
         int drawn;
         bit draw;
         bit absorb;
         bit b;
         logic [OUT_W-1:0] vl;
         logic [OUT_W-1:0] vm;
         len    = eff_len(req_len);
         draw   = req && !flush && (mq.size() >= len);
         drawn  = draw ? len : 0;
         absorb = rng_valid && !m_ext && !flush && (mq.size() - drawn + IN_W <= BUF_W);
         vl = '0;
         vm = '0;
         if (flush) begin
            mq.delete();
         end else begin
            if (draw) begin
               for (int i = 0; i < len; i++) begin
                  b = mq.pop_front();
                  vl[i] = b;
                  vm[len-1-i] = b;
               end
            end
            if (absorb) begin
               for (int i = 0; i < IN_W; i++) mq.push_back(rng[i]);
            end
         end
         m_ext    <= absorb;
         m_valid  <= draw;
         m_data_l <= vl;
         m_data_m <= vm;
      end
   end

   // Compare both instances with the model on every falling edge.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         logic exp_rdy;
         exp_rdy = !flush && (mq.size() >= eff_len(req_len));
         chk("lsb rng_extract", 128'(ext_l), 128'(m_ext));
         chk("lsb req_ready", 128'(rdy_l), 128'(exp_rdy));
         chk("lsb out_valid", 128'(ov_l), 128'(m_valid));
         chk("lsb out_data", 128'(od_l), 128'(m_data_l));
         chk("lsb fill", 128'(fill_l), 128'(mq.size()));
         chk("msb rng_extract", 128'(ext_m), 128'(m_ext));
         chk("msb req_ready", 128'(rdy_m), 128'(exp_rdy));
         chk("msb out_valid", 128'(ov_m), 128'(m_valid));
         chk("msb out_data", 128'(od_m), 128'(m_data_m));
         chk("msb fill", 128'(fill_m), 128'(mq.size()));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [7:0] pat;
      rst_n = 1'b0; rng_valid = 1'b0; rng = '0; flush = 1'b0; req = 1'b0; req_len = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();
      chk("reset fill", 128'(fill_l), 128'd0);
      chk("reset req_ready", 128'(rdy_l), 128'd0);
      chk("reset out_valid", 128'(ov_l), 128'd0);
      chk("reset out_data", 128'(od_l), 128'd0);
      chk("reset rng_extract", 128'(ext_l), 128'd0);

      // single word, LSB-order draws
      rng = W1; rng_valid = 1'b1;
      step();
      chk("absorb fill", 128'(fill_l), 128'd128);
      chk("absorb extract", 128'(ext_l), 128'd1);
      rng_valid = 1'b0; req = 1'b1; req_len = 7'd8;
      step();
      chk("draw8 data", 128'(od_l), 128'h00);
      chk("draw8 valid", 128'(ov_l), 128'd1);
      chk("draw8 fill", 128'(fill_l), 128'd120);
      chk("draw8 extract", 128'(ext_l), 128'd0);
      req_len = 7'd16;
      step();
      chk("draw16 data", 128'(od_l), 128'h2211);
      chk("draw16 fill", 128'(fill_l), 128'd104);
      req_len = 7'd32;
      step();
      chk("draw32 data", 128'(od_l), 128'h66554433);
      chk("draw32 fill", 128'(fill_l), 128'd72);
      req_len = 7'd64;
      step();
      chk("draw64 data", 128'(od_l), 128'hEEDDCCBB_AA998877);
      chk("draw64 fill", 128'(fill_l), 128'd8);
      req = 1'b0; rng = 128'h0F; rng_valid = 1'b1;
      step();
      chk("second word fill", 128'(fill_l), 128'd136);
      rng_valid = 1'b0; req = 1'b1; req_len = 7'd16;
      step();
      chk("span data", 128'(od_l), 128'h0FFF);
      chk("span fill", 128'(fill_l), 128'd120);
      req = 1'b0;

      // back-pressure
      flush = 1'b1;
      step();
      chk("flush fill", 128'(fill_l), 128'd0);
      flush = 1'b0; rng = W3; rng_valid = 1'b1;
      repeat (6) step();
      chk("full fill", 128'(fill_l), 128'd256);
      chk("full extract", 128'(ext_l), 128'd0);
      req = 1'b1; req_len = 7'd72;
      step();
      chk("blocked fill", 128'(fill_l), 128'd184);
      chk("blocked extract", 128'(ext_l), 128'd0);
      step();
      chk("unblocked fill", 128'(fill_l), 128'd240);
      chk("unblocked extract", 128'(ext_l), 128'd1);
      rng_valid = 1'b0; flush = 1'b1;
      step();
      chk("flush with req valid", 128'(ov_l), 128'd0);
      chk("flush with req fill", 128'(fill_l), 128'd0);
      flush = 1'b0; req = 1'b0;

      // length clamping
      rng = W4; rng_valid = 1'b1;
      step();
      rng_valid = 1'b0; req = 1'b1; req_len = 7'd28;
      step();
      chk("clamp pre fill", 128'(fill_l), 128'd100);
      req_len = 7'd0;
      step();
      chk("len0 fill", 128'(fill_l), 128'd28);
      chk("len0 valid", 128'(ov_l), 128'd1);
      req_len = 7'd100;
      #1;
      chk("len100 ready", 128'(rdy_l), 128'd0);
      step();
      chk("len100 no draw", 128'(ov_l), 128'd0);
      chk("len100 fill", 128'(fill_l), 128'd28);
      req = 1'b0;

      // back-to-back single-bit draws and draw order
      flush = 1'b1;
      step();
      flush = 1'b0; rng = 128'h3A5; rng_valid = 1'b1;
      step();
      rng_valid = 1'b0; req = 1'b1; req_len = 7'd1;
      pat = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("b2b valid", 128'(ov_l), 128'd1);
         chk("b2b lsb bit", 128'(od_l), 128'(pat[i]));
         chk("b2b msb bit", 128'(od_m), 128'(pat[i]));
      end
      req_len = 7'd4;
      step();
      chk("len4 lsb", 128'(od_l), 128'h3);
      chk("len4 msb", 128'(od_m), 128'hC);
      req = 1'b0;

      // asynchronous reset in the middle of a draw
      flush = 1'b1;
      step();
      flush = 1'b0; rng = W1; rng_valid = 1'b1;
      repeat (3) step();
      rng_valid = 1'b0; req = 1'b1; req_len = 7'd56;
      step();
      chk("pre-reset fill", 128'(fill_l), 128'd200);
      chk("pre-reset data", 128'(od_l), 128'h66554433221100);
      req_len = 7'd8;
      #1;
      rst_n = 1'b0;
      #1;
      chk("async fill", 128'(fill_l), 128'd0);
      chk("async valid", 128'(ov_l), 128'd0);
      chk("async data", 128'(od_l), 128'd0);
      chk("async extract", 128'(ext_l), 128'd0);
      req = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      chk("post-reset fill", 128'(fill_l), 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
